// File: rtl/adc_reg_if_type3.sv
`default_nettype none
// ============================================================================
// Module   : adc_reg_if_type3
// Brief    : uDMA cfg register file for AFE readout: per-channel L2 RX config,
//            global buffer/mask config, flag-event FIFO, W1C done status, IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module adc_reg_if_type3 #(
    parameter int L2_AWIDTH_NOAL  = 12,
    parameter int UDMA_TRANS_SIZE = 16,
    parameter int TRANS_SIZE      = 16,
    parameter int ADC_NUM_CHS     = 8,
    parameter int ADC_CHID_WIDTH  = 4,
    parameter int L2_NUM_CHS      = 4,
    parameter int BUF_AWIDTH      = 10,
    parameter int BUF_TRANS_SIZE  = 10,
    parameter int FLAG_DEPTH      = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rstn_i,
    input  logic [31:0]                           cfg_data_i,
    input  logic [10:0]                           cfg_addr_i,
    input  logic                                  cfg_valid_i,
    input  logic                                  cfg_rwn_i,
    output logic [31:0]                           cfg_data_o,
    output logic                                  cfg_ready_o,
    input  logic                                  cfg_flag_event_i,
    input  logic [31:0]                           cfg_flag_data_i,
    input  logic [L2_NUM_CHS-1:0]                 cfg_rx_done_i,
    output logic                                  irq_o,
    output logic [L2_NUM_CHS*L2_AWIDTH_NOAL-1:0]  cfg_rx_startaddr_o,
    output logic [L2_NUM_CHS*UDMA_TRANS_SIZE-1:0] cfg_rx_size_o,
    output logic [L2_NUM_CHS-1:0]                 cfg_rx_continuous_o,
    output logic [L2_NUM_CHS-1:0]                 cfg_rx_en_o,
    output logic [L2_NUM_CHS-1:0]                 cfg_rx_clr_o,
    output logic [L2_NUM_CHS*ADC_CHID_WIDTH-1:0]  cfg_rx_adc_chid_o,
    input  logic [L2_NUM_CHS-1:0]                 cfg_rx_en_i,
    input  logic [L2_NUM_CHS*L2_AWIDTH_NOAL-1:0]  cfg_rx_curr_addr_i,
    input  logic [L2_NUM_CHS*UDMA_TRANS_SIZE-1:0] cfg_rx_bytes_left_i,
    output logic [BUF_AWIDTH-1:0]                 cfg_buf_startaddr_o,
    output logic [BUF_TRANS_SIZE-1:0]             cfg_buf_size_o,
    output logic [BUF_TRANS_SIZE-1:0]             cfg_buf_flevel_o,
    output logic                                  cfg_buf_continuous_o,
    output logic                                  cfg_buf_en_o,
    output logic                                  cfg_buf_clr_o,
    input  logic                                  cfg_buf_en_i,
    input  logic [BUF_AWIDTH-1:0]                 cfg_buf_curr_addr_i,
    input  logic [BUF_TRANS_SIZE-1:0]             cfg_buf_bytes_left_i,
    output logic [1:0]                            cfg_data_mask_mode_o,
    output logic [ADC_NUM_CHS-1:0]                cfg_buf_ch_mask_o,
    output logic                                  cfg_buf_en_mode_o,
    output logic [ADC_CHID_WIDTH-1:0]             cfg_buf_en_chid_o
);

    localparam int PTR_W = $clog2(FLAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [L2_AWIDTH_NOAL-1:0] saddr_q [L2_NUM_CHS];
    logic [L2_AWIDTH_NOAL-1:0] saddr_d [L2_NUM_CHS];
    logic [TRANS_SIZE-1:0]     size_q  [L2_NUM_CHS];
    logic [TRANS_SIZE-1:0]     size_d  [L2_NUM_CHS];
    logic [ADC_CHID_WIDTH-1:0] chid_q  [L2_NUM_CHS];
    logic [ADC_CHID_WIDTH-1:0] chid_d  [L2_NUM_CHS];
    logic [L2_NUM_CHS-1:0]     cont_q, cont_d, en_p_q, en_p_d, clr_p_q, clr_p_d;
    logic [L2_NUM_CHS-1:0]     done_q, done_d, dmask_q, dmask_d;

    logic [BUF_AWIDTH-1:0]     buf_saddr_q, buf_saddr_d;
    logic [BUF_TRANS_SIZE-1:0] buf_size_q, buf_size_d, buf_flevel_q, buf_flevel_d;
    logic                      buf_cont_q, buf_cont_d, buf_en_p_q, buf_en_p_d, buf_clr_p_q, buf_clr_p_d;
    logic [ADC_NUM_CHS-1:0]    ch_mask_q, ch_mask_d;
    logic                      en_mode_q, en_mode_d;
    logic [ADC_CHID_WIDTH-1:0] en_chid_q, en_chid_d;
    logic [1:0]                mask_mode_q, mask_mode_d;
    logic                      flag_en_q, flag_en_d, done_irq_en_q, done_irq_en_d;
    logic                      ovf_q, ovf_d, irq_q, irq_d;

    logic [31:0]               mem_q [FLAG_DEPTH];
    logic [31:0]               mem_d [FLAG_DEPTH];
    logic [PTR_W-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]          count_q, count_d;

    logic [4:0]                w_ch;
    logic [2:0]                w_reg;
    logic [3:0]                w_gidx;
    logic                      w_glb, w_wr, w_rd;
    logic                      w_pop, w_push_req, w_push, w_full;
    logic [L2_NUM_CHS-1:0]     w_w1c;
    logic [31:0]               w_rdata;
    logic                      unused_bits;

    // Channels 30/31 form the 16-entry global space
    assign w_ch   = cfg_addr_i[7:3];
    assign w_reg  = cfg_addr_i[2:0];
    assign w_glb  = &w_ch[4:1];
    assign w_gidx = {cfg_addr_i[3], cfg_addr_i[2:0]};
    assign w_wr   = cfg_valid_i & ~cfg_rwn_i;
    assign w_rd   = cfg_valid_i & cfg_rwn_i;

    assign w_full     = (count_q == CNT_W'(FLAG_DEPTH));
    assign w_pop      = w_rd & w_glb & (w_gidx == 4'hD) & (count_q != '0);
    assign w_push_req = cfg_flag_event_i & flag_en_q;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_w1c      = (w_wr && w_glb && w_gidx == 4'hB) ? cfg_data_i[L2_NUM_CHS-1:0] : '0;

    assign unused_bits = ^{cfg_addr_i[10:8], cfg_data_i};

    always_comb begin
        for (int i = 0; i < L2_NUM_CHS; i++) begin
            saddr_d[i] = saddr_q[i];
            size_d[i]  = size_q[i];
            chid_d[i]  = chid_q[i];
        end
        for (int i = 0; i < FLAG_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        cont_d        = cont_q;
        en_p_d        = '0;
        clr_p_d       = '0;
        dmask_d       = dmask_q;
        buf_saddr_d   = buf_saddr_q;
        buf_size_d    = buf_size_q;
        buf_flevel_d  = buf_flevel_q;
        buf_cont_d    = buf_cont_q;
        buf_en_p_d    = 1'b0;
        buf_clr_p_d   = 1'b0;
        ch_mask_d     = ch_mask_q;
        en_mode_d     = en_mode_q;
        en_chid_d     = en_chid_q;
        mask_mode_d   = mask_mode_q;
        flag_en_d     = flag_en_q;
        done_irq_en_d = done_irq_en_q;
        ovf_d         = ovf_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        count_d       = count_q;

        if (w_wr && !w_glb) begin
            for (int i = 0; i < L2_NUM_CHS; i++) begin
                if (w_ch == 5'(i)) begin
                    case (w_reg)
                        3'd0: saddr_d[i] = {cfg_data_i[L2_AWIDTH_NOAL-1:2], 2'b00};
                        3'd1: size_d[i]  = {cfg_data_i[TRANS_SIZE-1:2], 2'b00};
                        3'd2: begin
                            clr_p_d[i] = cfg_data_i[5];
                            en_p_d[i]  = cfg_data_i[4];
                            cont_d[i]  = cfg_data_i[0];
                            chid_d[i]  = cfg_data_i[16 +: ADC_CHID_WIDTH];
                        end
                        default: ;
                    endcase
                end
            end
        end

        if (w_wr && w_glb) begin
            case (w_gidx)
                4'h0: buf_saddr_d  = cfg_data_i[BUF_AWIDTH-1:0];
                4'h1: buf_size_d   = cfg_data_i[BUF_TRANS_SIZE-1:0];
                4'h2: buf_flevel_d = cfg_data_i[BUF_TRANS_SIZE-1:0];
                4'h3: begin
                    buf_clr_p_d = cfg_data_i[5];
                    buf_en_p_d  = cfg_data_i[4];
                    buf_cont_d  = cfg_data_i[0];
                end
                4'h8: ch_mask_d = cfg_data_i[ADC_NUM_CHS-1:0];
                4'h9: begin
                    en_mode_d = cfg_data_i[31];
                    en_chid_d = cfg_data_i[ADC_CHID_WIDTH-1:0];
                end
                4'hA: mask_mode_d = cfg_data_i[1:0];
                4'hC: begin
                    done_irq_en_d = cfg_data_i[1];
                    flag_en_d     = cfg_data_i[0];
                end
                4'hE: if (cfg_data_i[31]) ovf_d = 1'b0;
                4'hF: dmask_d = cfg_data_i[L2_NUM_CHS-1:0];
                default: ;
            endcase
        end

        // A new done pulse outranks a simultaneous W1C on the same bit
        done_d = (done_q & ~w_w1c) | cfg_rx_done_i;

        if (w_push) begin
            mem_d[wptr_q] = cfg_flag_data_i;
            wptr_d        = wptr_q + 1'b1;
        end
        if (w_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (w_pop && !w_push) begin
            count_d = count_q - 1'b1;
        end
        if (w_push_req && w_full && !w_pop) begin
            ovf_d = 1'b1;
        end

        irq_d = (flag_en_q & (count_q != '0)) | (done_irq_en_q & |(done_q & dmask_q));
    end

    always_comb begin
        w_rdata = '0;
        if (!w_glb) begin
            for (int i = 0; i < L2_NUM_CHS; i++) begin
                if (w_ch == 5'(i)) begin
                    case (w_reg)
                        3'd0: w_rdata = 32'(cfg_rx_curr_addr_i[i*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]);
                        3'd1: w_rdata = 32'(cfg_rx_bytes_left_i[i*UDMA_TRANS_SIZE +: UDMA_TRANS_SIZE]);
                        3'd2: begin
                            w_rdata[16 +: ADC_CHID_WIDTH] = chid_q[i];
                            w_rdata[4]                    = cfg_rx_en_i[i];
                            w_rdata[2:1]                  = 2'b10;
                            w_rdata[0]                    = cont_q[i];
                        end
                        default: ;
                    endcase
                end
            end
        end else begin
            case (w_gidx)
                4'h0: w_rdata = 32'(cfg_buf_curr_addr_i);
                4'h1: w_rdata = 32'(cfg_buf_bytes_left_i);
                4'h2: w_rdata = 32'(buf_flevel_q);
                4'h3: begin
                    w_rdata[4]   = cfg_buf_en_i;
                    w_rdata[2:1] = 2'b10;
                    w_rdata[0]   = buf_cont_q;
                end
                4'h8: w_rdata = 32'(ch_mask_q);
                4'h9: begin
                    w_rdata[31]                  = en_mode_q;
                    w_rdata[ADC_CHID_WIDTH-1:0]  = en_chid_q;
                end
                4'hA: w_rdata = 32'(mask_mode_q);
                4'hB: w_rdata = 32'(done_q);
                4'hC: w_rdata = {30'd0, done_irq_en_q, flag_en_q};
                4'hD: if (count_q != '0) w_rdata = mem_q[rptr_q];
                4'hE: begin
                    w_rdata[31]  = ovf_q;
                    w_rdata[7:0] = 8'(count_q);
                end
                4'hF: w_rdata = 32'(dmask_q);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < L2_NUM_CHS; i++) begin
                saddr_q[i] <= '0;
                size_q[i]  <= '0;
                chid_q[i]  <= '0;
            end
            for (int i = 0; i < FLAG_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            cont_q        <= '0;
            en_p_q        <= '0;
            clr_p_q       <= '0;
            done_q        <= '0;
            dmask_q       <= '0;
            buf_saddr_q   <= '0;
            buf_size_q    <= '0;
            buf_flevel_q  <= '0;
            buf_cont_q    <= 1'b0;
            buf_en_p_q    <= 1'b0;
            buf_clr_p_q   <= 1'b0;
            ch_mask_q     <= '1;
            en_mode_q     <= 1'b0;
            en_chid_q     <= '0;
            mask_mode_q   <= '0;
            flag_en_q     <= 1'b0;
            done_irq_en_q <= 1'b0;
            ovf_q         <= 1'b0;
            irq_q         <= 1'b0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
        end else begin
            for (int i = 0; i < L2_NUM_CHS; i++) begin
                saddr_q[i] <= saddr_d[i];
                size_q[i]  <= size_d[i];
                chid_q[i]  <= chid_d[i];
            end
            for (int i = 0; i < FLAG_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            cont_q        <= cont_d;
            en_p_q        <= en_p_d;
            clr_p_q       <= clr_p_d;
            done_q        <= done_d;
            dmask_q       <= dmask_d;
            buf_saddr_q   <= buf_saddr_d;
            buf_size_q    <= buf_size_d;
            buf_flevel_q  <= buf_flevel_d;
            buf_cont_q    <= buf_cont_d;
            buf_en_p_q    <= buf_en_p_d;
            buf_clr_p_q   <= buf_clr_p_d;
            ch_mask_q     <= ch_mask_d;
            en_mode_q     <= en_mode_d;
            en_chid_q     <= en_chid_d;
            mask_mode_q   <= mask_mode_d;
            flag_en_q     <= flag_en_d;
            done_irq_en_q <= done_irq_en_d;
            ovf_q         <= ovf_d;
            irq_q         <= irq_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
        end
    end

    generate
        for (genvar g = 0; g < L2_NUM_CHS; g++) begin : g_ch
            assign cfg_rx_startaddr_o[g*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL] = saddr_q[g];
            assign cfg_rx_size_o[g*UDMA_TRANS_SIZE +: UDMA_TRANS_SIZE]    = UDMA_TRANS_SIZE'(size_q[g]);
            assign cfg_rx_adc_chid_o[g*ADC_CHID_WIDTH +: ADC_CHID_WIDTH]  = chid_q[g];
        end
    endgenerate

    assign cfg_data_o           = w_rdata;
    assign cfg_ready_o          = 1'b1;
    assign irq_o                = irq_q;
    assign cfg_rx_continuous_o  = cont_q;
    assign cfg_rx_en_o          = en_p_q;
    assign cfg_rx_clr_o         = clr_p_q;
    assign cfg_buf_startaddr_o  = buf_saddr_q;
    assign cfg_buf_size_o       = buf_size_q;
    assign cfg_buf_flevel_o     = buf_flevel_q;
    assign cfg_buf_continuous_o = buf_cont_q;
    assign cfg_buf_en_o         = buf_en_p_q;
    assign cfg_buf_clr_o        = buf_clr_p_q;
    assign cfg_data_mask_mode_o = mask_mode_q;
    assign cfg_buf_ch_mask_o    = ch_mask_q;
    assign cfg_buf_en_mode_o    = en_mode_q;
    assign cfg_buf_en_chid_o    = en_chid_q;

endmodule
`default_nettype wire
